// File: rtl/controlador_demux_if.sv
// Bundle of the upstream valid/ready word port and the demux control/acknowledge lines.
// Upstream handshake: a word moves on a rising edge where in_valid && in_ready; the source holds in_data/in_dest while in_valid is high and not yet accepted.
interface controlador_demux_if #(
    parameter int DATA_BITS = 32
);
    logic                 in_valid;
    logic                 in_ready;
    logic [DATA_BITS-1:0] in_data;
    logic                 in_dest;
    logic                 selector;
    logic [DATA_BITS-1:0] demux_data;
    logic                 wr_out1;
    logic                 wr_out2;
    logic                 ack_out1;
    logic                 ack_out2;

    // Source of words plus the two destinations (drives valid/data/acks).
    modport master (
        output in_valid, in_data, in_dest, ack_out1, ack_out2,
        input  in_ready, selector, demux_data, wr_out1, wr_out2
    );

    // The sequencing controller.
    modport slave (
        input  in_valid, in_data, in_dest, ack_out1, ack_out2,
        output in_ready, selector, demux_data, wr_out1, wr_out2
    );
endinterface

// File: rtl/controlador_demux.sv
// Sequencing controller for a two-output demux: captures a word, strobes the chosen
// destination for one cycle, then waits (bounded) for that destination's acknowledge.
module controlador_demux #(
    parameter int DATA_BITS      = 32,
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_BITS       = 16
) (
    input  logic                clk,
    input  logic                reset,
    controlador_demux_if.slave  bus,
    input  logic                err_clear,
    output logic                busy,
    output logic                timeout_err,
    output logic [CNT_BITS-1:0] cnt_out1,
    output logic [CNT_BITS-1:0] cnt_out2,
    output logic [1:0]          state_dbg
);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_DISPATCH = 2'd1,
        S_WAIT     = 2'd2
    } state_t;

    localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_t               state_q, state_d;
    logic                 sel_q, sel_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic [15:0]          wcnt_q, wcnt_d;
    logic [CNT_BITS-1:0]  c1_q, c1_d;
    logic [CNT_BITS-1:0]  c2_q, c2_d;
    logic                 err_q, err_d;
    logic                 ack_sel;

    logic                 in_ready_o;
    logic                 busy_o;
    logic                 wr1_o;
    logic                 wr2_o;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            sel_q   <= 1'b0;
            data_q  <= '0;
            wcnt_q  <= '0;
            c1_q    <= '0;
            c2_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            data_q  <= data_d;
            wcnt_q  <= wcnt_d;
            c1_q    <= c1_d;
            c2_q    <= c2_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        data_d  = data_q;
        wcnt_d  = wcnt_q;
        c1_d    = c1_q;
        c2_d    = c2_q;
        err_d   = err_q;
        // Only the addressed destination's acknowledge counts.
        ack_sel = sel_q ? bus.ack_out2 : bus.ack_out1;

        if (err_clear) err_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.in_valid) begin
                    sel_d   = bus.in_dest;
                    data_d  = bus.in_data;
                    state_d = S_DISPATCH;
                end
            end
            S_DISPATCH: begin
                wcnt_d  = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // An ack on the last allowed cycle is checked first, so it beats the timeout.
                if (ack_sel) begin
                    if (sel_q) c2_d = c2_q + 1'b1;
                    else       c1_d = c1_q + 1'b1;
                    state_d = S_IDLE;
                end else if (wcnt_q == WAIT_LAST) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    wcnt_d = wcnt_q + 16'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready_o = (state_q == S_IDLE);
        busy_o     = (state_q != S_IDLE);
        wr1_o      = (state_q == S_DISPATCH) && !sel_q;
        wr2_o      = (state_q == S_DISPATCH) &&  sel_q;
    end

    assign bus.in_ready   = in_ready_o;
    assign bus.selector   = sel_q;
    assign bus.demux_data = data_q;
    assign bus.wr_out1    = wr1_o;
    assign bus.wr_out2    = wr2_o;
    assign busy           = busy_o;
    assign timeout_err    = err_q;
    assign cnt_out1       = c1_q;
    assign cnt_out2       = c2_q;
    assign state_dbg      = state_q;

endmodule

// File: tb/tb_controlador_demux.sv
// Directed bench for controlador_demux with a short timeout (4) and 4-bit counters.
module tb_controlador_demux;

    localparam int DW = 32;
    localparam int TO = 4;
    localparam int CB = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          err_clear = 1'b0;
    logic          busy;
    logic          timeout_err;
    logic [CB-1:0] cnt_out1;
    logic [CB-1:0] cnt_out2;
    logic [1:0]    state_dbg;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int exp_c1   = 0;
    int exp_c2   = 0;
    int last_dispatch;

    controlador_demux_if #(.DATA_BITS(DW)) bus ();

    controlador_demux #(
        .DATA_BITS(DW),
        .TIMEOUT_CYCLES(TO),
        .CNT_BITS(CB)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus),
        .err_clear  (err_clear),
        .busy       (busy),
        .timeout_err(timeout_err),
        .cnt_out1   (cnt_out1),
        .cnt_out2   (cnt_out2),
        .state_dbg  (state_dbg)
    );

    // clock / reset block
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #20000;
        $display("FAIL watchdog: observed time limit reached, required end of directed sequence");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic chk_idle_reset();
        chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_selector", 64'(bus.selector), 64'd0);
        chk("rst_data", 64'(bus.demux_data), 64'd0);
        chk("rst_wr1", 64'(bus.wr_out1), 64'd0);
        chk("rst_wr2", 64'(bus.wr_out2), 64'd0);
        chk("rst_err", 64'(timeout_err), 64'd0);
        chk("rst_cnt1", 64'(cnt_out1), 64'd0);
        chk("rst_cnt2", 64'(cnt_out2), 64'd0);
    endtask

    // driver: presents one word, takes the transfer edge, drops valid
    task automatic launch(input logic [DW-1:0] d, input logic dest);
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_dest  = dest;
        tick();
        bus.in_valid = 1'b0;
        bus.in_data  = '1;
        bus.in_dest  = ~dest;
        chk("disp_selector", 64'(bus.selector), 64'(dest));
        chk("disp_data", 64'(bus.demux_data), 64'(d));
        chk("disp_wr1", 64'(bus.wr_out1), 64'(!dest));
        chk("disp_wr2", 64'(bus.wr_out2), 64'(dest));
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        #2;
        reset = 1'b0;
        exp_c1 = 0;
        exp_c2 = 0;
    endtask

    logic [DW-1:0] words [4];
    logic          dests [4];

    initial begin
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        bus.in_dest  = 1'b0;
        bus.ack_out1 = 1'b0;
        bus.ack_out2 = 1'b0;
        words = '{32'h1111_0001, 32'h2222_0002, 32'h3333_0003, 32'h4444_0004};
        dests = '{1'b1, 1'b0, 1'b1, 1'b0};

        // reset state
        tick();
        tick();
        chk_idle_reset();
        reset = 1'b0;
        tick();
        chk_idle_reset();

        // single dispatch to out1, ack one cycle after the strobe
        launch(32'hDEADBEEF, 1'b0);
        chk("single_in_ready_disp", 64'(bus.in_ready), 64'd0);
        tick();
        chk("single_wr1_one_cycle", 64'(bus.wr_out1), 64'd0);
        chk("single_wr2_low", 64'(bus.wr_out2), 64'd0);
        chk("single_busy_wait", 64'(busy), 64'd1);
        bus.ack_out1 = 1'b1;
        tick();
        bus.ack_out1 = 1'b0;
        exp_c1++;
        chk("single_in_ready_back", 64'(bus.in_ready), 64'd1);
        chk("single_cnt1", 64'(cnt_out1), 64'(exp_c1));
        chk("single_cnt2", 64'(cnt_out2), 64'(exp_c2));
        chk("single_data_hold", 64'(bus.demux_data), 64'hDEADBEEF);

        // alternating stream, valid held high, immediate acks
        pulse_reset();
        tick();
        bus.ack_out1 = 1'b1;
        bus.ack_out2 = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_data  = words[0];
        bus.in_dest  = dests[0];
        last_dispatch = -1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("stream_selector", 64'(bus.selector), 64'(dests[i]));
            chk("stream_data", 64'(bus.demux_data), 64'(words[i]));
            chk("stream_wr1", 64'(bus.wr_out1), 64'(!dests[i]));
            chk("stream_wr2", 64'(bus.wr_out2), 64'(dests[i]));
            if (last_dispatch >= 0) chk("stream_period", 64'(cyc - last_dispatch), 64'd3);
            last_dispatch = cyc;
            if (i < 3) begin
                bus.in_data = words[i+1];
                bus.in_dest = dests[i+1];
            end else begin
                bus.in_valid = 1'b0;
            end
            tick();
            chk("stream_data_stable", 64'(bus.demux_data), 64'(words[i]));
            tick();
            if (dests[i]) exp_c2++;
            else          exp_c1++;
            chk("stream_in_ready", 64'(bus.in_ready), 64'd1);
        end
        bus.ack_out1 = 1'b0;
        bus.ack_out2 = 1'b0;
        chk("stream_cnt1", 64'(cnt_out1), 64'(exp_c1));
        chk("stream_cnt2", 64'(cnt_out2), 64'(exp_c2));

        // wrong ack ignored, then timeout
        launch(32'hA5A5_0001, 1'b1);
        bus.ack_out1 = 1'b1;
        tick();
        for (int k = 0; k < TO - 1; k++) begin
            tick();
            chk("to_busy", 64'(busy), 64'd1);
            chk("to_err_early", 64'(timeout_err), 64'd0);
        end
        tick();
        bus.ack_out1 = 1'b0;
        chk("to_err_set", 64'(timeout_err), 64'd1);
        chk("to_in_ready", 64'(bus.in_ready), 64'd1);
        chk("to_cnt2_same", 64'(cnt_out2), 64'(exp_c2));
        chk("to_cnt1_same", 64'(cnt_out1), 64'(exp_c1));

        // next word still accepted, flag sticky
        launch(32'h0000_BEEF, 1'b0);
        bus.ack_out1 = 1'b1;
        tick();
        tick();
        bus.ack_out1 = 1'b0;
        exp_c1++;
        chk("after_to_cnt1", 64'(cnt_out1), 64'(exp_c1));
        chk("after_to_err_sticky", 64'(timeout_err), 64'd1);
        err_clear = 1'b1;
        tick();
        err_clear = 1'b0;
        chk("err_cleared", 64'(timeout_err), 64'd0);

        // boundary: ack on the last allowed WAIT cycle wins
        launch(32'hB0B0_0002, 1'b1);
        tick();
        for (int k = 0; k < TO - 1; k++) tick();
        chk("bound_still_wait", 64'(busy), 64'd1);
        bus.ack_out2 = 1'b1;
        tick();
        bus.ack_out2 = 1'b0;
        exp_c2++;
        chk("bound_cnt2", 64'(cnt_out2), 64'(exp_c2));
        chk("bound_err_low", 64'(timeout_err), 64'd0);
        chk("bound_idle", 64'(bus.in_ready), 64'd1);

        // set and clear on the same edge: set wins
        launch(32'hC0C0_0003, 1'b0);
        err_clear = 1'b1;
        tick();
        for (int k = 0; k < TO; k++) tick();
        chk("setclr_err", 64'(timeout_err), 64'd1);
        tick();
        err_clear = 1'b0;
        chk("setclr_then_clear", 64'(timeout_err), 64'd0);

        // asynchronous reset while in WAIT
        launch(32'hD0D0_0004, 1'b1);
        tick();
        tick();
        chk("async_pre_busy", 64'(busy), 64'd1);
        reset = 1'b1;
        #1;
        chk_idle_reset();
        #1;
        reset = 1'b0;
        exp_c1 = 0;
        exp_c2 = 0;
        tick();

        // counter wrap on out2
        bus.ack_out2 = 1'b1;
        for (int n = 0; n < 16; n++) begin
            launch(32'(n), 1'b1);
            tick();
            tick();
            exp_c2 = (exp_c2 + 1) % 16;
            if (n == 14) chk("wrap_cnt2_15", 64'(cnt_out2), 64'd15);
        end
        bus.ack_out2 = 1'b0;
        chk("wrap_cnt2_zero", 64'(cnt_out2), 64'(exp_c2));
        chk("wrap_cnt1_zero", 64'(cnt_out1), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/controlador_demux.md
# controlador_demux

Sequencing controller for the two-output demultiplexer in the console datapath. It accepts data words from an upstream valid/ready source. For each word it drives the demux `selector` and `data` inputs, strobes the selected destination, and waits for that destination's acknowledge. A bounded timeout stops a dead destination from stalling the stream. It sits between the command/data source and the demux, and owns the demux control lines exclusively.

## Interface
Parameters:
- `DATA_BITS`, 32: width of the data word and of the demux data input.
- `TIMEOUT_CYCLES`, 255: maximum WAIT cycles before abort; legal range 1–65535.
- `CNT_BITS`, 16: width of each per-destination dispatch counter.

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state immediately.
- `in_valid`  in  1  upstream word available.
- `in_ready`  out  1  controller can accept a word.
- `in_data`  in  DATA_BITS  word to route.
- `in_dest`  in  1  destination: 0 = out1, 1 = out2.
- `selector`  out  1  drives the demux selector.
- `demux_data`  out  DATA_BITS  drives the demux data input.
- `wr_out1` / `wr_out2`  out  1  one-cycle write strobe to destination 1 / 2.
- `ack_out1` / `ack_out2`  in  1  destination 1 / 2 acknowledge.
- `busy`  out  1  high whenever state ≠ IDLE.
- `timeout_err`  out  1  sticky abort flag.
- `err_clear`  in  1  clears `timeout_err`.
- `cnt_out1` / `cnt_out2`  out  CNT_BITS  count of words successfully delivered to each destination.

## Operation
- Reset values: state IDLE, `selector`=0, `demux_data`=0, `wr_out*`=0, `timeout_err`=0, counters=0, wait counter=0, `in_ready`=1, `busy`=0.
- `in_ready` = (state == IDLE). Transfer occurs on an edge where `in_valid` & `in_ready`.
- IDLE:
  - On transfer, register `in_data` into `demux_data` and `in_dest` into `selector`, then go to DISPATCH.
  - Otherwise hold `selector`/`demux_data` at their last values. This keeps the demux outputs stable between words.
- DISPATCH (exactly 1 cycle):
  - `wr_out1` = ~`selector`, `wr_out2` = `selector`.
  - Acks are ignored in this state.
  - Next state WAIT; wait counter cleared to 0.
- WAIT:
  - Only the ack of the selected destination is sampled; the other ack is ignored.
  - Selected ack high at an edge: increment that destination's counter (wraps max→0), go to IDLE.
  - No ack and wait counter == TIMEOUT_CYCLES-1: set `timeout_err`, no counter update, go to IDLE.
  - Otherwise the wait counter increments.
  - Ack on the final allowed cycle wins over timeout.
- `selector` and `demux_data` are stable from the capture edge until the next transfer edge, including across DISPATCH and WAIT.
- `timeout_err` clears on an edge with `err_clear`=1. If set and clear coincide on the same edge, set wins. The flag does not block operation.
- `wr_out1`/`wr_out2` are never high together and never high outside DISPATCH.
- Reset asserted mid-transaction aborts it immediately: outputs go to reset values, no strobe completes, counters clear.

## Timing
- Edge E0: transfer; `selector`/`demux_data` valid after E0.
- Cycle E0–E1: DISPATCH, write strobe high.
- Edge E1: enter WAIT.
- Edge E2: earliest ack sample; counter updates at E2; `in_ready` high after E2.
- Best-case throughput: one word per 3 cycles with back-to-back `in_valid`. With an immediate ack, the next transfer can occur at E3.
- Worst case: WAIT lasts TIMEOUT_CYCLES cycles. `timeout_err` is visible after edge E1+TIMEOUT_CYCLES.
- All outputs are registered or decoded from registered state only; no combinational path from inputs to outputs.

## Test plan
- Reset then idle: after `reset` pulse, all outputs at reset values and `in_ready`=1. Asserting `reset` while in WAIT returns to IDLE asynchronously, before the next edge.
- Single dispatch to out1: `in_data`=0xDEADBEEF, `in_dest`=0, ack_out1 one cycle after the strobe.
  - Required: `selector`=0, `demux_data`=0xDEADBEEF, `wr_out1` high exactly 1 cycle, `wr_out2` low.
  - `cnt_out1`=1, `cnt_out2`=0, `in_ready` back after 3 cycles.
- Alternating stream: 4 words, destinations 1,0,1,0, immediate acks.
  - Required: selector sequence 1,0,1,0; each counter = 2; one word per 3 cycles.
- Wrong-ack ignored and timeout: TIMEOUT_CYCLES=4, dest=1, only `ack_out1` pulses.
  - Required: `timeout_err`=1 after 4 WAIT cycles; `cnt_out2` unchanged; next word accepted.
- Boundary ack: TIMEOUT_CYCLES=4, `ack_out2` on 4th WAIT cycle → delivered, `timeout_err` stays 0. Separately, `err_clear` on the same edge a timeout occurs → flag ends at 1.
- Counter wrap: CNT_BITS=4, 16 deliveries to out2 → `cnt_out2` reads 0; `cnt_out1` unaffected.
